// File: rtl/serial_alu_pkg.sv
// Shared types and helpers for the digit-serial ALU: opcodes, FSM states and
// per-opcode decode of operand-B inversion and compare-only results.
package serial_alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_OR   = 3'd3,
        OP_AND  = 3'd4,
        OP_SLT  = 3'd5,
        OP_SLTU = 3'd6,
        OP_EQ   = 3'd7
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Compare ops yield only a flag; their rd digits are forced to zero.
    function automatic logic is_cmp(input alu_op_e op);
        return (op == OP_SLT) || (op == OP_SLTU) || (op == OP_EQ);
    endfunction

    // Subtraction-based ops add ~B with an initial carry of 1.
    function automatic logic inv_b(input alu_op_e op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational DW-bit ALU slice: add/sub with carry chaining between beats,
// bitwise logic ops, and a per-digit equality flag.
module serial_alu_slice
    import serial_alu_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_carry,
    input  alu_op_e       i_op,
    output logic [DW-1:0] o_rd,
    output logic          o_carry,
    output logic          o_eq
);

    logic [DW-1:0] w_b;
    logic [DW:0]   w_sum;

    assign w_b     = inv_b(i_op) ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b} + {{DW{1'b0}}, i_carry};
    assign o_carry = w_sum[DW];
    assign o_eq    = (i_a == i_b);

    // Compare ops keep the difference here so the top can read its MSB for SLT.
    always_comb begin
        o_rd = w_sum[DW-1:0];
        case (i_op)
            OP_XOR:  o_rd = i_a ^ i_b;
            OP_OR:   o_rd = i_a | i_b;
            OP_AND:  o_rd = i_a & i_b;
            default: o_rd = w_sum[DW-1:0];
        endcase
    end

endmodule

// File: rtl/serial_alu_digit.sv
// Digit-serial integer ALU: LSB-digit-first operands, one registered result digit
// per accepted beat. Optional macro SERIAL_ALU_EARLY_EQ_EN ends EQ at the first mismatch.
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DW   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  alu_op_e       i_op,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd,
    output logic          o_last,
    output logic          o_done,
    output logic          o_cmp
);

    localparam int            BEATS    = XLEN / DW;
    localparam int            CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    state_e        r_state;
    alu_op_e       r_op;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_eq;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd;
    logic          r_last;
    logic          r_done;
    logic          r_cmp;

    logic [DW-1:0] w_rd;
    logic          w_carry;
    logic          w_eq;
    logic          w_cmp;
    logic          w_early;
    logic          w_end;

    serial_alu_slice #(.DW(DW)) u_slice (
        .i_a     (i_a),
        .i_b     (i_b),
        .i_carry (r_carry),
        .i_op    (r_op),
        .o_rd    (w_rd),
        .o_carry (w_carry),
        .o_eq    (w_eq)
    );

    // Final-beat compare flag; SLT falls back to the difference sign when signs agree.
    always_comb begin
        w_cmp = 1'b0;
        case (r_op)
            OP_SLT:  w_cmp = (i_a[DW-1] != i_b[DW-1]) ? i_a[DW-1] : w_rd[DW-1];
            OP_SLTU: w_cmp = ~w_carry;
            OP_EQ:   w_cmp = r_eq & w_eq;
            default: w_cmp = 1'b0;
        endcase
    end

`ifdef SERIAL_ALU_EARLY_EQ_EN
    assign w_early = (r_op == OP_EQ) && !w_eq;
`else
    assign w_early = 1'b0;
`endif

    assign w_end   = (r_cnt == LAST_CNT) || w_early;
    assign o_ready = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= OP_ADD;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_eq       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd       <= '0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_cmp      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd       <= '0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_cmp      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_cnt   <= '0;
                        r_eq    <= 1'b1;
                        r_carry <= inv_b(i_op);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (i_valid) begin
                        r_rd_valid <= 1'b1;
                        r_rd       <= is_cmp(r_op) ? '0 : w_rd;
                        r_carry    <= w_carry;
                        r_eq       <= r_eq & w_eq;
                        if (w_end) begin
                            r_cnt   <= '0;
                            r_last  <= 1'b1;
                            r_done  <= 1'b1;
                            r_cmp   <= w_cmp;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd       = r_rd;
    assign o_last     = r_last;
    assign o_done     = r_done;
    assign o_cmp      = r_cmp;

endmodule
